// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
package bcd_pkg;

   localparam int unsigned DIGIT_W = 4;

   localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
   localparam logic [DIGIT_W-1:0] BCD_CORR = 4'd6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // True when a nibble is not a legal decimal digit.
   function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
      return d > BCD_MAX;
   endfunction

endpackage

// File: rtl/bcd_serial_adder_ctrl_if.sv
// Requester-side handshake and result bus of the serial BCD adder.
interface bcd_serial_adder_ctrl_if #(
   parameter int unsigned DIGITS = 4
) ();

   logic                  start;
   logic [4*DIGITS-1:0]   a;
   logic [4*DIGITS-1:0]   b;
   logic                  cin;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   sum;
   logic                  cout;
   logic                  err;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, err
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, err
   );

endinterface

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder: binary add, then +6 correction when the raw sum exceeds 9.
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  logic               cin,
   output logic [DIGIT_W-1:0] sum_c,
   output logic               cout_c
);

   logic [DIGIT_W:0] raw;

   // Carry-in enters only the raw sum; the correction add is carry-free and wraps mod 16.
   always_comb begin
      raw    = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
      sum_c  = raw[DIGIT_W-1:0];
      cout_c = 1'b0;
      if (raw > {1'b0, BCD_MAX}) begin
         sum_c  = raw[DIGIT_W-1:0] + BCD_CORR;
         cout_c = 1'b1;
      end
   end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial multi-digit BCD adder: one shared digit adder, LSD first,
// decimal carry rippled through a flop between cycles.
module bcd_serial_adder_ctrl
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   bcd_serial_adder_ctrl_if.slave    bus
);

   localparam int unsigned W     = DIGIT_W * DIGITS;
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

   state_t           state, state_n;
   logic [IDX_W-1:0] idx, idx_n;
   logic [W-1:0]     opa, opa_n;
   logic [W-1:0]     opb, opb_n;
   logic             carry, carry_n;
   logic [W-1:0]     sum_q, sum_n;
   logic             cout_q, cout_n;
   logic             err_q, err_n;
   logic             busy_q, busy_n;
   logic             done_q, done_n;

   logic [DIGIT_W-1:0] a_dig_c, b_dig_c, dig_sum_c;
   logic               dig_cout_c;
   logic               inv_c;

   // Operand digit-select muxes feeding the shared adder.
   always_comb begin
      a_dig_c = opa[32'(idx) * DIGIT_W +: DIGIT_W];
      b_dig_c = opb[32'(idx) * DIGIT_W +: DIGIT_W];
   end

   bcd_digit_add u_digit (
      .a      (a_dig_c),
      .b      (b_dig_c),
      .cin    (carry),
      .sum_c  (dig_sum_c),
      .cout_c (dig_cout_c)
   );

   // Invalid-digit scan over the operands being offered for latching.
   always_comb begin
      inv_c = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         inv_c = inv_c | digit_invalid(bus.a[i*DIGIT_W +: DIGIT_W])
                       | digit_invalid(bus.b[i*DIGIT_W +: DIGIT_W]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         idx    <= '0;
         opa    <= '0;
         opb    <= '0;
         carry  <= 1'b0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         err_q  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_n;
         idx    <= idx_n;
         opa    <= opa_n;
         opb    <= opb_n;
         carry  <= carry_n;
         sum_q  <= sum_n;
         cout_q <= cout_n;
         err_q  <= err_n;
         busy_q <= busy_n;
         done_q <= done_n;
      end
   end

   // Next-state and next-output logic; busy/done are computed one cycle ahead so they come out of flops.
   always_comb begin
      state_n = state;
      idx_n   = idx;
      opa_n   = opa;
      opb_n   = opb;
      carry_n = carry;
      sum_n   = sum_q;
      cout_n  = cout_q;
      err_n   = err_q;
      busy_n  = 1'b0;
      done_n  = 1'b0;

      unique case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               opa_n   = bus.a;
               opb_n   = bus.b;
               carry_n = bus.cin;
               sum_n   = '0;
               idx_n   = '0;
               err_n   = inv_c;
               busy_n  = 1'b1;
               state_n = RUN;
            end else if (state == DONE) begin
               state_n = IDLE;
            end
         end
         RUN: begin
            sum_n[32'(idx) * DIGIT_W +: DIGIT_W] = dig_sum_c;
            carry_n = dig_cout_c;
            idx_n   = idx + IDX_W'(1);
            if (idx == LAST) begin
               cout_n  = dig_cout_c;
               done_n  = 1'b1;
               state_n = DONE;
            end else begin
               busy_n  = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Self-checking bench for bcd_serial_adder_ctrl: directed vectors with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_bcd_serial_adder_ctrl;

   localparam int unsigned DIGITS = 4;
   localparam int unsigned W      = 4 * DIGITS;

   logic clk = 1'b0;
   logic rst = 1'b1;

   bcd_serial_adder_ctrl_if #(.DIGITS(DIGITS)) bus ();

   bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Decimal add, digit by digit, following the raw/+6 rule; returns {cout, sum}.
   function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin);
      int c;
      int raw;
      logic [W-1:0] s;
      c = int'(cin);
      s = '0;
      for (int i = 0; i < DIGITS; i++) begin
         raw = int'(a[i*4 +: 4]) + int'(b[i*4 +: 4]) + c;
         if (raw > 9) begin
            raw = (raw + 6) % 16;
            c   = 1;
         end else begin
            c   = 0;
         end
         s[i*4 +: 4] = 4'(raw);
      end
      return {1'(c), s};
   endfunction

   function automatic logic ref_err(input logic [W-1:0] a, input logic [W-1:0] b);
      logic e;
      e = 1'b0;
      for (int i = 0; i < DIGITS; i++)
         if (a[i*4 +: 4] > 4'd9 || b[i*4 +: 4] > 4'd9) e = 1'b1;
      return e;
   endfunction

   function automatic logic [W-1:0] rand_bcd();
      logic [W-1:0] v;
      for (int i = 0; i < DIGITS; i++)
         v[i*4 +: 4] = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 9));
      return v;
   endfunction

   // Behavioural model: remaining-digit countdown plus the expected visible outputs.
   int           m_rem      = 0;
   logic         m_done     = 1'b0;
   logic [W-1:0] m_sum      = '0;
   logic         m_cout     = 1'b0;
   logic         m_err      = 1'b0;
   logic [W:0]   m_pend     = '0;
   int           m_done_cnt = 0;
   int           d_done_cnt = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_rem  = 0;
         m_done = 1'b0;
         m_sum  = '0;
         m_cout = 1'b0;
         m_err  = 1'b0;
      end else if (m_rem == 0 && bus.start) begin
         m_pend = ref_add(bus.a, bus.b, bus.cin);
         m_err  = ref_err(bus.a, bus.b);
         m_rem  = DIGITS;
         m_done = 1'b0;
      end else if (m_rem > 0) begin
         m_rem--;
         if (m_rem == 0) begin
            m_done = 1'b1;
            m_sum  = m_pend[W-1:0];
            m_cout = m_pend[W];
            m_done_cnt++;
         end
      end else begin
         m_done = 1'b0;
      end
   end

   // Cycle-by-cycle comparison, sampled on the falling edge.
   always @(negedge clk) begin
      chk("busy", 64'(bus.busy), 64'(m_rem > 0));
      chk("done", 64'(bus.done), 64'(m_done));
      chk("err",  64'(bus.err),  64'(m_err));
      chk("busy_and_done", 64'(bus.busy & bus.done), 64'(0));
      if (m_rem == 0) begin
         chk("sum",  64'(bus.sum),  64'(m_sum));
         chk("cout", 64'(bus.cout), 64'(m_cout));
      end
      if (bus.done === 1'b1) d_done_cnt++;
   end

   task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic [W-1:0] exp_sum,
                         input logic exp_cout, input logic exp_err);
      int lat;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.cin   = cin;
      lat = 0;
      do begin
         @(negedge clk);
         bus.start = 1'b0;
         lat++;
      end while (bus.done !== 1'b1 && lat < 20);
      chk({name, "_latency"}, 64'(lat), 64'(DIGITS + 1));
      chk({name, "_sum"},  64'(bus.sum),  64'(exp_sum));
      chk({name, "_cout"}, 64'(bus.cout), 64'(exp_cout));
      chk({name, "_err"},  64'(bus.err),  64'(exp_err));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ndone;
      int lat;
      logic [W-1:0] got_sum;

      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
      rst       = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_busy", 64'(bus.busy), 64'(0));
      chk("reset_done", 64'(bus.done), 64'(0));
      chk("reset_sum",  64'(bus.sum),  64'(0));
      chk("reset_cout", 64'(bus.cout), 64'(0));
      chk("reset_err",  64'(bus.err),  64'(0));
      rst = 1'b0;

      // Hand-computed values that pin the model.
      chk("model_1234_5678", 64'(ref_add(16'h1234, 16'h5678, 1'b0)), 64'h06912);
      chk("model_9999_0001", 64'(ref_add(16'h9999, 16'h0001, 1'b0)), 64'h10000);
      chk("model_cin_only",  64'(ref_add(16'h0000, 16'h0000, 1'b1)), 64'h00001);
      chk("model_invalid",   64'(ref_add(16'h00F0, 16'h0000, 1'b0)), 64'h00150);
      chk("model_err",       64'(ref_err(16'h00F0, 16'h0000)),       64'(1));

      run_op("basic",   16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
      run_op("wrap",    16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("cin",     16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
      run_op("invalid", 16'h00F0, 16'h0000, 1'b0, 16'h0150, 1'b0, 1'b1);

      // start re-pulsed during RUN must be ignored
      @(negedge clk);
      bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h5678; bus.cin = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222;
      @(negedge clk);
      bus.start = 1'b0;
      ndone = 0;
      got_sum = '0;
      repeat (10) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            ndone++;
            got_sum = bus.sum;
         end
      end
      chk("ignore_start_done_count", 64'(ndone), 64'(1));
      chk("ignore_start_sum", 64'(got_sum), 64'h6912);

      // reset in the middle of RUN abandons the operation
      @(negedge clk);
      bus.start = 1'b1; bus.a = 16'h00F0; bus.b = 16'h0000; bus.cin = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", 64'(bus.busy), 64'(0));
      chk("midrst_done", 64'(bus.done), 64'(0));
      chk("midrst_sum",  64'(bus.sum),  64'(0));
      chk("midrst_cout", 64'(bus.cout), 64'(0));
      chk("midrst_err",  64'(bus.err),  64'(0));
      ndone = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.done === 1'b1) ndone++;
      end
      chk("midrst_no_done", 64'(ndone), 64'(0));
      run_op("after_rst", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);

      // back-to-back: new start held during the done cycle
      @(negedge clk);
      bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h5678; bus.cin = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         bus.start = 1'b0;
         lat++;
      end while (bus.done !== 1'b1 && lat < 20);
      chk("b2b_first_sum", 64'(bus.sum), 64'h6912);
      bus.start = 1'b1; bus.a = 16'h0005; bus.b = 16'h0005; bus.cin = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         bus.start = 1'b0;
         lat++;
      end while (bus.done !== 1'b1 && lat < 20);
      chk("b2b_latency", 64'(lat), 64'(DIGITS + 1));
      chk("b2b_sum",  64'(bus.sum),  64'h0010);
      chk("b2b_cout", 64'(bus.cout), 64'(0));

      // randomized traffic, including starts during RUN and occasional resets
      repeat (4000) begin
         @(negedge clk);
         rst       = ($urandom_range(0, 299) == 0);
         bus.start = ($urandom_range(0, 2) == 0);
         bus.a     = rand_bcd();
         bus.b     = rand_bcd();
         bus.cin   = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      rst       = 1'b0;
      bus.start = 1'b0;
      repeat (DIGITS + 3) @(negedge clk);
      chk("done_pulse_total", 64'(d_done_cnt), 64'(m_done_cnt));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_serial_adder_ctrl.md
# bcd_serial_adder_ctrl

Digit-serial multi-digit BCD adder controller. It time-shares one combinational 4-bit BCD digit adder across `DIGITS` packed BCD digits, least-significant digit first, and ripples the decimal carry through a register between cycles. It sits between a requester that issues a start/operands handshake and the shared digit adder. It returns a packed BCD sum, decimal carry-out, a one-cycle `done` pulse and an invalid-digit flag.

## Interface
- `DIGITS`, default 4: number of BCD digits per operand; legal range 1–16.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only in IDLE or DONE.
- `a` input 4*DIGITS: operand A, packed BCD, digit 0 in bits [3:0].
- `b` input 4*DIGITS: operand B, same packing.
- `cin` input 1: decimal carry into digit 0.
- `busy` output 1: high while digits are being processed (RUN).
- `done` output 1: one-cycle pulse; `sum`/`cout`/`err` are valid from this cycle on.
- `sum` output 4*DIGITS: packed BCD result.
- `cout` output 1: decimal carry out of the top digit.
- `err` output 1: at least one latched operand digit was greater than 9.

## Operation
- States: IDLE, RUN, DONE.
- IDLE or DONE with `start`=1:
  - latch `a`, `b`, `cin` into operand registers;
  - clear the `sum` register;
  - digit index ← 0;
  - `err` ← OR over all latched digits of (digit > 9);
  - go to RUN.
- DONE with `start`=0 → IDLE.
- RUN, each cycle, for digit i:
  - raw = A[i] + B[i] + carry, computed 5 bits wide;
  - if raw > 9: digit = (raw + 6) mod 16 and carry ← 1;
  - else: digit = raw and carry ← 0;
  - write the digit to `sum[4i+3:4i]`; i ← i + 1.
- When i = DIGITS−1 is processed → DONE, and `cout` ← the final carry.
- `start` in RUN is ignored. No queueing; the requester must re-assert it.
- Invalid digits (> 9) are still processed by the rule above. The result is deterministic but not meaningful, and `err` flags it.
- Outputs `sum`, `cout`, `err` hold their values until the next accepted `start`.
- Reset values: state IDLE, `busy`=0, `done`=0, `sum`=0, `cout`=0, `err`=0, carry=0, index=0.
- `rst` has priority over everything, including in RUN. An in-flight operation is abandoned with no `done`.

## Timing
- Start accepted at edge k. `busy`=1 from after edge k until after edge k+DIGITS.
- Digit i is written at edge k+1+i.
- `done`=1 for exactly the cycle following edge k+DIGITS. `busy` is 0 in that cycle.
- Latency from start to done is DIGITS+1 cycles. For DIGITS=1: `busy` lasts one cycle, and `done` follows at k+1.
- Back-to-back: `start`=1 during the `done` cycle is accepted, so throughput is one operation per DIGITS+1 cycles.
- `done` and `busy` are never high together.
- `err` is valid from the cycle after acceptance onward.
- `sum` digits update progressively during RUN. Only values at `done` or later are architecturally valid.
- No combinational path from inputs to outputs. All outputs are registered.

## Structure
- Shared package `bcd_pkg`:
  - state enum (IDLE/RUN/DONE);
  - constants `BCD_MAX` = 9 and `BCD_CORR` = 6;
  - digit width 4.
- One sub-module, `bcd_digit_add`: combinational, inputs 4+4+1, outputs 4-bit digit plus carry, implementing the raw/correction rule above.
  - The correction add uses carry-in 0. The incoming carry is applied only once, in the raw sum.
- The controller holds:
  - the FSM;
  - the digit index counter, width clog2(DIGITS), minimum 1;
  - operand registers;
  - the carry flop;
  - the result register;
  - the one digit-select mux per operand feeding `bcd_digit_add`.

## Test plan
- DIGITS=4: a=0x1234, b=0x5678, cin=0 → `done` at cycle 5 after start, `sum`=0x6912, `cout`=0, `err`=0.
- a=0x9999, b=0x0001, cin=0 → `sum`=0x0000, `cout`=1. Also a=0x0000, b=0x0000, cin=1 → `sum`=0x0001, `cout`=0.
- a=0x00F0, b=0x0000 → `err`=1. Digit 1: raw 15 → digit 5, carry 1, so `sum`=0x0150 and `cout`=0.
- `start` pulsed again two cycles into RUN with different operands → ignored. Original result 0x6912 delivered; exactly one `done`.
- `rst` asserted at cycle 3 of RUN → next cycle: state IDLE, all outputs 0, no `done`. A fresh start then completes normally.
- Back-to-back: `start` held during the `done` cycle with a=0x0005, b=0x0005 → second `done` 5 cycles later, `sum`=0x0010, `cout`=0.
